// File: rtl/regfile_mp_if.sv
`default_nettype none
// ==== regfile_mp_if : decode/writeback bus of the multi-port register file (rev 1.0) ====
interface regfile_mp_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] sr1_in;
   logic [ADDR_W-1:0] sr2_in;
   logic [DATA_W-1:0] sr1_out;
   logic [DATA_W-1:0] sr2_out;
   logic              sr1_busy_out;
   logic              sr2_busy_out;
   logic              we0_in;
   logic [ADDR_W-1:0] rd0_in;
   logic [DATA_W-1:0] data0_in;
   logic              we1_in;
   logic [ADDR_W-1:0] rd1_in;
   logic [DATA_W-1:0] data1_in;
   logic              hold_in;
   logic              busy_set_in;
   logic [ADDR_W-1:0] busy_addr_in;
   logic [DATA_W-1:0] mon_out;

   modport master (
      output sr1_in, sr2_in, we0_in, rd0_in, data0_in, we1_in, rd1_in, data1_in,
             hold_in, busy_set_in, busy_addr_in,
      input  sr1_out, sr2_out, sr1_busy_out, sr2_busy_out, mon_out
   );

   modport slave (
      input  sr1_in, sr2_in, we0_in, rd0_in, data0_in, we1_in, rd1_in, data1_in,
             hold_in, busy_set_in, busy_addr_in,
      output sr1_out, sr2_out, sr1_busy_out, sr2_busy_out, mon_out
   );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ==== regfile_mp : 2R/2W register file with write-stage bypass and busy scoreboard (rev 1.0) ====
module regfile_mp #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0,
   parameter int MON_ADDR = 0
) (
   input  logic         clk,
   input  logic         reset_n_in,
   regfile_mp_if.slave  bus
);
   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] MON_IDX = ADDR_W'(MON_ADDR);
   localparam bit              ZERO_EN = (ZERO_REG != 0);

   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [DEPTH-1:0]             busy_q, busy_d;

   logic              l0_vld_q, l0_vld_d;
   logic [ADDR_W-1:0] l0_rd_q, l0_rd_d;
   logic [DATA_W-1:0] l0_data_q, l0_data_d;
   logic              l1_vld_q, l1_vld_d;
   logic [ADDR_W-1:0] l1_rd_q, l1_rd_d;
   logic [DATA_W-1:0] l1_data_q, l1_data_d;

   // Writes to a hardwired zero register die here so they can never bypass or commit.
   always_comb begin : capture
      l0_vld_d  = bus.we0_in & ~bus.hold_in & ~(ZERO_EN && (bus.rd0_in == '0));
      l0_rd_d   = bus.rd0_in;
      l0_data_d = bus.data0_in;
      l1_vld_d  = bus.we1_in & ~bus.hold_in & ~(ZERO_EN && (bus.rd1_in == '0));
      l1_rd_d   = bus.rd1_in;
      l1_data_d = bus.data1_in;
   end

   always_comb begin : commit
      mem_d = mem_q;
      if (l0_vld_q) mem_d[l0_rd_q] = l0_data_q;
      if (l1_vld_q) mem_d[l1_rd_q] = l1_data_q;
   end

   // Set is applied after the port-1 clear so a coincident set wins.
   always_comb begin : scoreboard
      busy_d = busy_q;
      if (l1_vld_q) busy_d[l1_rd_q] = 1'b0;
      if (bus.busy_set_in && !(ZERO_EN && (bus.busy_addr_in == '0)))
         busy_d[bus.busy_addr_in] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n_in) begin
         mem_q    <= '0;
         busy_q   <= '0;
         l0_vld_q <= 1'b0;
         l1_vld_q <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         busy_q   <= busy_d;
         l0_vld_q <= l0_vld_d;
         l1_vld_q <= l1_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      l0_rd_q   <= l0_rd_d;
      l0_data_q <= l0_data_d;
      l1_rd_q   <= l1_rd_d;
      l1_data_q <= l1_data_d;
   end

   logic [ADDR_W-1:0] sr_addr [2];
   assign sr_addr[0] = bus.sr1_in;
   assign sr_addr[1] = bus.sr2_in;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [DATA_W-1:0] rdata;
      logic              rbusy;
      always_comb begin
         rdata = mem_q[sr_addr[p]];
         if (l0_vld_q && (l0_rd_q == sr_addr[p])) rdata = l0_data_q;
         if (l1_vld_q && (l1_rd_q == sr_addr[p])) rdata = l1_data_q;
         if (!reset_n_in || (ZERO_EN && (sr_addr[p] == '0))) rdata = '0;
         rbusy = busy_q[sr_addr[p]] & reset_n_in;
      end
   end

   assign bus.sr1_out      = g_rd[0].rdata;
   assign bus.sr2_out      = g_rd[1].rdata;
   assign bus.sr1_busy_out = g_rd[0].rbusy;
   assign bus.sr2_busy_out = g_rd[1].rbusy;
   assign bus.mon_out      = reset_n_in ? mem_q[MON_IDX] : '0;
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ==== tb_regfile_mp : directed checks of regfile_mp (ZERO_REG=1, MON_ADDR=3) (rev 1.0) ====
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   regfile_mp_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   regfile_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .MON_ADDR(3)) dut (
      .clk        (clk),
      .reset_n_in (rst_n),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we0_in = 0; bus.we1_in = 0; bus.hold_in = 0; bus.busy_set_in = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      step();
      step();
      rst_n = 1;
      step();
      for (int a = 0; a < 8; a++) begin
         bus.sr1_in = 3'(a); bus.sr2_in = 3'(7 - a);
         #1;
         checks++; if (bus.sr1_out !== 8'h00) begin errors++; $display("FAIL reset_sr1 a=%0d got %h exp 00", a, bus.sr1_out); end
         checks++; if (bus.sr2_out !== 8'h00) begin errors++; $display("FAIL reset_sr2 a=%0d got %h exp 00", a, bus.sr2_out); end
         checks++; if (bus.sr1_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy1 a=%0d got %b exp 0", a, bus.sr1_busy_out); end
         checks++; if (bus.sr2_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy2 a=%0d got %b exp 0", a, bus.sr2_busy_out); end
      end
      checks++; if (bus.mon_out !== 8'h00) begin errors++; $display("FAIL reset_mon got %h exp 00", bus.mon_out); end
   endtask

   task automatic test_write();
      bus.we0_in = 1; bus.rd0_in = 3; bus.data0_in = 8'h5A;
      step();
      idle();
      bus.sr1_in = 3;
      #1;
      checks++; if (bus.sr1_out !== 8'h5A) begin errors++; $display("FAIL write_bypass got %h exp 5a", bus.sr1_out); end
      checks++; if (bus.mon_out !== 8'h00) begin errors++; $display("FAIL write_mon_early got %h exp 00", bus.mon_out); end
      step();
      checks++; if (bus.mon_out !== 8'h5A) begin errors++; $display("FAIL write_mon_commit got %h exp 5a", bus.mon_out); end
      checks++; if (bus.sr1_out !== 8'h5A) begin errors++; $display("FAIL write_array got %h exp 5a", bus.sr1_out); end
   endtask

   task automatic test_conflict();
      bus.we0_in = 1; bus.rd0_in = 2; bus.data0_in = 8'h11;
      bus.we1_in = 1; bus.rd1_in = 2; bus.data1_in = 8'h22;
      step();
      idle();
      bus.sr2_in = 2;
      #1;
      checks++; if (bus.sr2_out !== 8'h22) begin errors++; $display("FAIL conflict_bypass got %h exp 22", bus.sr2_out); end
      step();
      checks++; if (bus.sr2_out !== 8'h22) begin errors++; $display("FAIL conflict_commit got %h exp 22", bus.sr2_out); end
      bus.hold_in = 1; bus.we0_in = 1; bus.rd0_in = 2; bus.data0_in = 8'h33;
      step();
      idle();
      #1;
      checks++; if (bus.sr2_out !== 8'h22) begin errors++; $display("FAIL hold_bypass got %h exp 22", bus.sr2_out); end
      step();
      checks++; if (bus.sr2_out !== 8'h22) begin errors++; $display("FAIL hold_commit got %h exp 22", bus.sr2_out); end
   endtask

   task automatic test_scoreboard();
      bus.busy_set_in = 1; bus.busy_addr_in = 5;
      bus.sr1_in = 5; bus.sr2_in = 4;
      #1;
      checks++; if (bus.sr1_busy_out !== 1'b0) begin errors++; $display("FAIL busy_no_bypass got %b exp 0", bus.sr1_busy_out); end
      step();
      idle();
      #1;
      checks++; if (bus.sr1_busy_out !== 1'b1) begin errors++; $display("FAIL busy_set got %b exp 1", bus.sr1_busy_out); end
      checks++; if (bus.sr2_busy_out !== 1'b0) begin errors++; $display("FAIL busy_other got %b exp 0", bus.sr2_busy_out); end
      bus.we1_in = 1; bus.rd1_in = 5; bus.data1_in = 8'h44;
      step();
      idle();
      #1;
      checks++; if (bus.sr1_busy_out !== 1'b1) begin errors++; $display("FAIL busy_clear_early got %b exp 1", bus.sr1_busy_out); end
      step();
      checks++; if (bus.sr1_busy_out !== 1'b0) begin errors++; $display("FAIL busy_clear got %b exp 0", bus.sr1_busy_out); end
      checks++; if (bus.sr1_out !== 8'h44) begin errors++; $display("FAIL busy_clear_data got %h exp 44", bus.sr1_out); end
      bus.we1_in = 1; bus.rd1_in = 5; bus.data1_in = 8'h45;
      step();
      idle();
      bus.busy_set_in = 1; bus.busy_addr_in = 5;
      step();
      idle();
      #1;
      checks++; if (bus.sr1_busy_out !== 1'b1) begin errors++; $display("FAIL busy_set_wins got %b exp 1", bus.sr1_busy_out); end
      bus.we0_in = 1; bus.rd0_in = 5; bus.data0_in = 8'h46;
      step();
      idle();
      step();
      checks++; if (bus.sr1_busy_out !== 1'b1) begin errors++; $display("FAIL busy_port0 got %b exp 1", bus.sr1_busy_out); end
      checks++; if (bus.sr1_out !== 8'h46) begin errors++; $display("FAIL port0_data got %h exp 46", bus.sr1_out); end
   endtask

   task automatic test_zero_reg();
      bus.we0_in = 1; bus.rd0_in = 0; bus.data0_in = 8'hFF;
      bus.we1_in = 1; bus.rd1_in = 0; bus.data1_in = 8'hEE;
      step();
      idle();
      bus.sr1_in = 0; bus.sr2_in = 0;
      #1;
      checks++; if (bus.sr1_out !== 8'h00) begin errors++; $display("FAIL zero_bypass got %h exp 00", bus.sr1_out); end
      step();
      checks++; if (bus.sr2_out !== 8'h00) begin errors++; $display("FAIL zero_commit got %h exp 00", bus.sr2_out); end
      bus.busy_set_in = 1; bus.busy_addr_in = 0;
      step();
      idle();
      #1;
      checks++; if (bus.sr1_busy_out !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", bus.sr1_busy_out); end
   endtask

   task automatic test_back_to_back();
      bus.sr1_in = 6;
      bus.we0_in = 1; bus.rd0_in = 6; bus.data0_in = 8'h01;
      step();
      bus.data0_in = 8'h02;
      step();
      idle();
      #1;
      checks++; if (bus.sr1_out !== 8'h02) begin errors++; $display("FAIL b2b_bypass got %h exp 02", bus.sr1_out); end
      step();
      checks++; if (bus.sr1_out !== 8'h02) begin errors++; $display("FAIL b2b_commit got %h exp 02", bus.sr1_out); end
      bus.we1_in = 1; bus.rd1_in = 6; bus.data1_in = 8'h03;
      step();
      idle();
      bus.we0_in = 1; bus.rd0_in = 6; bus.data0_in = 8'h04;
      step();
      idle();
      #1;
      checks++; if (bus.sr1_out !== 8'h04) begin errors++; $display("FAIL b2b_mixed got %h exp 04", bus.sr1_out); end
      step();
      checks++; if (bus.sr1_out !== 8'h04) begin errors++; $display("FAIL b2b_mixed_commit got %h exp 04", bus.sr1_out); end
   endtask

   task automatic test_reset_mid();
      bus.we0_in = 1; bus.rd0_in = 4; bus.data0_in = 8'h77;
      step();
      idle();
      bus.sr1_in = 4; bus.sr2_in = 5;
      #1;
      checks++; if (bus.sr1_out !== 8'h77) begin errors++; $display("FAIL mid_bypass got %h exp 77", bus.sr1_out); end
      rst_n = 0;
      step();
      rst_n = 1;
      #1;
      checks++; if (bus.sr1_out !== 8'h00) begin errors++; $display("FAIL mid_reg4 got %h exp 00", bus.sr1_out); end
      checks++; if (bus.sr2_busy_out !== 1'b0) begin errors++; $display("FAIL mid_busy5 got %b exp 0", bus.sr2_busy_out); end
      checks++; if (bus.mon_out !== 8'h00) begin errors++; $display("FAIL mid_mon got %h exp 00", bus.mon_out); end
      step();
      checks++; if (bus.sr1_out !== 8'h00) begin errors++; $display("FAIL mid_no_commit got %h exp 00", bus.sr1_out); end
   endtask

   initial begin
      bus.sr1_in = 0; bus.sr2_in = 0;
      bus.we0_in = 0; bus.rd0_in = 0; bus.data0_in = 0;
      bus.we1_in = 0; bus.rd1_in = 0; bus.data1_in = 0;
      bus.hold_in = 0; bus.busy_set_in = 0; bus.busy_addr_in = 0;
      test_reset();
      test_write();
      test_conflict();
      test_scoreboard();
      test_zero_reg();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
